// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the fixed banded SPD system (diag 20, off-diagonals -13/+6/-1).
// Loads b serially, sweeps one unknown per cycle in place, then streams x out with a valid/ready handshake.
module gsim_param #(
    parameter int N  = 16,
    parameter int BW = 16,
    parameter int XW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_en,
    input  logic signed [BW-1:0] b_in,
    input  logic [15:0]          max_iter,
    input  logic signed [XW-1:0] tol,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [XW-1:0] x_out,
    output logic                 busy,
    output logic [15:0]          iter_used
);
    localparam int IW = $clog2(N);
    localparam int NW = XW + 8;
    localparam int PW = NW + 18;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SWEEP = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [NW-1:0] C13     = NW'(13);
    localparam logic signed [NW-1:0] C6      = NW'(6);
    localparam logic signed [PW-1:0] C_RECIP = PW'(52429);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        ld_idx_q, ld_idx_d;
    logic [IW-1:0]        sw_idx_q, sw_idx_d;
    logic [IW-1:0]        out_idx_q, out_idx_d;
    logic [15:0]          max_iter_q, max_iter_d;
    logic [15:0]          iter_q, iter_d;
    logic signed [XW-1:0] tol_q, tol_d;
    logic signed [XW:0]   dmax_q, dmax_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic signed [XW-1:0] x_out_q, x_out_d;

    logic signed [BW-1:0] b_q [N];
    logic signed [XW-1:0] x_q [N];

    logic                 b_wr, x_wr, x_clr;
    logic [IW-1:0]        b_wr_idx;
    logic [IW-1:0]        out_nxt;
    logic [15:0]          iter_lim;
    logic signed [XW:0]   tol_ext;

    logic signed [NW-1:0] xm1, xp1, xm2, xp2, xm3, xp3, b_ext, num;
    logic signed [PW-1:0] num_w, prod, quot;
    logic signed [XW-1:0] x_new, x_old;
    logic signed [XW:0]   diff, absd, dcur;

    function automatic logic signed [XW-1:0] sat_xw(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] hi, lo;
        hi = {{(PW-XW+1){1'b0}}, {(XW-1){1'b1}}};
        lo = {{(PW-XW+1){1'b1}}, {(XW-1){1'b0}}};
        if (v > hi) return {1'b0, {(XW-1){1'b1}}};
        if (v < lo) return {1'b1, {(XW-1){1'b0}}};
        return v[XW-1:0];
    endfunction

    // Neighbour fetch: out-of-range indices read as zero.
    always_comb begin
        int si;
        si  = int'(sw_idx_q);
        xm1 = '0; xp1 = '0; xm2 = '0; xp2 = '0; xm3 = '0; xp3 = '0;
        for (int k = 0; k < N; k++) begin
            if (k == si - 1) xm1 = x_q[k];
            if (k == si + 1) xp1 = x_q[k];
            if (k == si - 2) xm2 = x_q[k];
            if (k == si + 2) xp2 = x_q[k];
            if (k == si - 3) xm3 = x_q[k];
            if (k == si + 3) xp3 = x_q[k];
        end
    end

    // 52429 / 2^20 approximates 1/20, the reciprocal of the diagonal.
    always_comb begin
        b_ext = b_q[sw_idx_q];
        num   = (b_ext <<< 16) + C13 * (xm1 + xp1) - C6 * (xm2 + xp2) + (xm3 + xp3);
        num_w = num;
        prod  = num_w * C_RECIP;
        quot  = prod >>> 20;
        x_new = sat_xw(quot);
        x_old = x_q[sw_idx_q];
        diff  = {x_new[XW-1], x_new} - {x_old[XW-1], x_old};
        absd  = diff[XW] ? -diff : diff;
        dcur  = (sw_idx_q == '0 || absd > dmax_q) ? absd : dmax_q;
    end

    assign iter_lim = (max_iter_q == 16'd0) ? 16'd1 : max_iter_q;
    assign tol_ext  = tol_q;
    assign out_nxt  = out_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ld_idx_d    = ld_idx_q;
        sw_idx_d    = sw_idx_q;
        out_idx_d   = out_idx_q;
        max_iter_d  = max_iter_q;
        iter_d      = iter_q;
        tol_d       = tol_q;
        dmax_d      = dmax_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        x_out_d     = x_out_q;
        b_wr        = 1'b0;
        b_wr_idx    = ld_idx_q;
        x_wr        = 1'b0;
        x_clr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_en) begin
                    b_wr       = 1'b1;
                    b_wr_idx   = '0;
                    max_iter_d = max_iter;
                    tol_d      = tol;
                    iter_d     = 16'd0;
                    busy_d     = 1'b1;
                    ld_idx_d   = IW'(1);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_en) begin
                    b_wr = 1'b1;
                    if (ld_idx_q == IW'(N-1)) begin
                        x_clr    = 1'b1;
                        sw_idx_d = '0;
                        state_d  = S_SWEEP;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                x_wr   = 1'b1;
                dmax_d = dcur;
                if (sw_idx_q == IW'(N-1)) begin
                    iter_d   = iter_q + 16'd1;
                    sw_idx_d = '0;
                    if (dcur < tol_ext || iter_d == iter_lim) begin
                        out_idx_d = '0;
                        state_d   = S_OUT;
                    end
                end else begin
                    sw_idx_d = sw_idx_q + 1'b1;
                end
            end
            default: begin
                // First OUT cycle primes the output register; afterwards advance only on handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    x_out_d     = x_q[out_idx_q];
                end else if (out_ready) begin
                    if (out_idx_q == IW'(N-1)) begin
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        out_idx_d = out_nxt;
                        x_out_d   = x_q[out_nxt];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ld_idx_q    <= '0;
            sw_idx_q    <= '0;
            out_idx_q   <= '0;
            max_iter_q  <= '0;
            iter_q      <= '0;
            tol_q       <= '0;
            dmax_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            ld_idx_q    <= ld_idx_d;
            sw_idx_q    <= sw_idx_d;
            out_idx_q   <= out_idx_d;
            max_iter_q  <= max_iter_d;
            iter_q      <= iter_d;
            tol_q       <= tol_d;
            dmax_q      <= dmax_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            x_out_q     <= x_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (b_wr) b_q[b_wr_idx] <= b_in;
        if (x_clr) begin
            for (int k = 0; k < N; k++) x_q[k] <= '0;
        end else if (x_wr) begin
            x_q[sw_idx_q] <= x_new;
        end
    end

    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign busy      = busy_q;
    assign iter_used = iter_q;

endmodule

// File: tb/tb_gsim_param.sv
// Scoreboard bench for gsim_param: stimulus pushes expected x/iter pairs, a monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_gsim_param;
    localparam int N  = 16;
    localparam int BW = 16;
    localparam int XW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_en = 1'b0;
    logic [BW-1:0] b_in = '0;
    logic [15:0]   max_iter = '0;
    logic [XW-1:0] tol = '0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [XW-1:0] x_out;
    logic          busy;
    logic [15:0]   iter_used;

    gsim_param #(.N(N), .BW(BW), .XW(XW)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in),
        .max_iter(max_iter), .tol(tol), .out_ready(out_ready),
        .out_valid(out_valid), .x_out(x_out), .busy(busy), .iter_used(iter_used)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] x; logic [15:0] it; } exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          bvec[N];
    longint      mx[N];
    int          m_it;
    logic [31:0] cap[N];
    int          cap_n = 0;
    int          bp_mode = 0;
    logic        stall_vld = 1'b0;
    logic [31:0] stall_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic longint mget(input int j);
        if (j < 0 || j >= N) return 0;
        return mx[j];
    endfunction

    // Reference Gauss-Seidel in 64-bit integers, straight from the update formula.
    task automatic run_model(input int mi, input longint tolv);
        longint num, nx, d, ad;
        int lim;
        lim  = (mi == 0) ? 1 : mi;
        m_it = 0;
        for (int i = 0; i < N; i++) mx[i] = 0;
        do begin
            d = 0;
            for (int i = 0; i < N; i++) begin
                num = (longint'(bvec[i]) <<< 16) + 13 * (mget(i-1) + mget(i+1))
                      - 6 * (mget(i-2) + mget(i+2)) + mget(i-3) + mget(i+3);
                nx = (num * 64'sd52429) >>> 20;
                if (nx > 64'sd2147483647) nx = 64'sd2147483647;
                else if (nx < -64'sd2147483648) nx = -64'sd2147483648;
                ad = (nx > mx[i]) ? nx - mx[i] : mx[i] - nx;
                if (ad > d) d = ad;
                mx[i] = nx;
            end
            m_it++;
        end while (!(d < tolv || m_it == lim));
    endtask

    task automatic push_model();
        cap_n = 0;
        for (int i = 0; i < N; i++) sb.push_back('{x: mx[i][31:0], it: 16'(m_it)});
    endtask

    task automatic load(input int mi, input logic [31:0] tl, input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps && (i == 4 || i == 8 || i == 12)) begin
                in_en = 1'b0;
                b_in  = 16'h5A5A;
                @(posedge clk); #1;
            end
            in_en = 1'b1;
            b_in  = 16'(bvec[i]);
            if (i == 0) begin
                max_iter = 16'(mi);
                tol      = tl;
            end
            @(posedge clk); #1;
            max_iter = 16'hFFFF;
            tol      = 32'h7FFF_FFFF;
        end
        in_en = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit pulses);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            if (pulses && n < 20) begin
                in_en = n[0];
                b_in  = 16'(n * 77);
            end else begin
                in_en = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        in_en = 1'b0;
        chk({name, "_finish"}, 32'(n < budget), 32'd1);
        @(negedge clk);
        chk({name, "_valid_low"}, 32'(out_valid), 32'd0);
        chk({name, "_busy_low"}, 32'(busy), 32'd0);
        chk({name, "_outputs"}, 32'(cap_n), 32'(N));
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_mode != 0) begin
                case ($urandom_range(0, 3))
                    0, 3:    out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_vld = 1'b0;
            end else begin
                if (stall_vld && out_valid) chk("stall_hold", x_out, stall_val);
                stall_vld = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("x%0d", cap_n), x_out, e.x);
                        chk($sformatf("iter_at_x%0d", cap_n), 32'(iter_used), 32'(e.it));
                        if (cap_n < N) cap[cap_n] = x_out;
                        cap_n++;
                    end
                end else if (out_valid) begin
                    stall_vld = 1'b1;
                    stall_val = x_out;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gold[N];
        int  b2[N];
        int  n;
        real xv[N];
        real r, mse;
        int  coef[4];
        gold = '{1, 0, -1, 2, 1, 0, 0, -2, 1, 1, 0, -1, 2, 0, 1, -1};
        b2   = '{3, -2, 7, 0, -5, 4, 1, 1, -3, 6, 2, -7, 0, 5, -1, 2};
        coef = '{20, -13, 6, -1};

        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x_out", x_out, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_iter_used", 32'(iter_used), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero right-hand side converges after one sweep.
        for (int i = 0; i < N; i++) bvec[i] = 0;
        cap_n = 0;
        for (int i = 0; i < N; i++) sb.push_back('{x: 32'h0, it: 16'd1});
        load(10, 32'd1, 1'b0);
        wait_done("zero_rhs", 2000, 1'b0);

        // Single sweep with b[0]=20: first two elements hand-derived.
        bvec[0] = 20;
        run_model(1, 0);
        mx[0] = 64'h0001_0000;
        mx[1] = 64'h0000_A666;
        m_it  = 1;
        push_model();
        load(1, 32'd0, 1'b0);
        wait_done("single_sweep", 2000, 1'b0);

        // max_iter=0 behaves as a single sweep.
        push_model();
        load(0, 32'd0, 1'b0);
        wait_done("max_iter_zero", 2000, 1'b0);

        // Golden problem, 200 sweeps, residual checked in real arithmetic.
        for (int i = 0; i < N; i++) bvec[i] = gold[i];
        run_model(200, 0);
        push_model();
        load(200, 32'd0, 1'b0);
        wait_done("golden", 10000, 1'b0);
        for (int i = 0; i < N; i++) xv[i] = $itor($signed(cap[i])) / 65536.0;
        mse = 0.0;
        for (int i = 0; i < N; i++) begin
            r = 20.0 * xv[i] - $itor(bvec[i]);
            for (int o = 1; o <= 3; o++) begin
                if (i - o >= 0) r = r + $itor(coef[o]) * xv[i-o];
                if (i + o < N)  r = r + $itor(coef[o]) * xv[i+o];
            end
            mse = mse + r * r;
        end
        mse = mse / N;
        chk("golden_mean_sq_residual_lt_1e-6", 32'(mse < 1.0e-6), 32'd1);

        // Backpressure on the output.
        for (int i = 0; i < N; i++) bvec[i] = b2[i];
        run_model(3, 0);
        push_model();
        bp_mode = 1;
        load(3, 32'd0, 1'b0);
        wait_done("backpressure", 4000, 1'b0);
        bp_mode = 0;

        // Gap-free then gapped load with stray in_en during the sweep: same expected result.
        run_model(5, 0);
        push_model();
        load(5, 32'd0, 1'b0);
        wait_done("gapfree", 4000, 1'b0);
        push_model();
        load(5, 32'd0, 1'b1);
        wait_done("gapped", 4000, 1'b1);

        // Reset during sweep 2 discards the problem; only the new one is emitted.
        for (int i = 0; i < N; i++) bvec[i] = gold[i];
        load(50, 32'd0, 1'b0);
        n = 0;
        while (iter_used != 16'd1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_reach_sweep2", 32'(n < 200), 32'd1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_valid", 32'(out_valid), 32'd0);
        chk("rstmid_iter", 32'(iter_used), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rstlow_busy", 32'(busy), 32'd0);
            chk("rstlow_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) bvec[i] = b2[N-1-i];
        run_model(4, 0);
        push_model();
        load(4, 32'd0, 1'b0);
        wait_done("after_reset", 4000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gsim_param.md
GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16: number of unknowns (4..64).
REQ-002 Parameter BW, default 16: width of b_in, signed integer.
REQ-003 Parameter XW, default 32: width of x_out, signed two's complement fixed point with 16 fraction bits (Q(XW-16).16).
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset; clears all state immediately on assertion.
REQ-006 in_en  input  1: b_in valid strobe.
REQ-007 b_in  input  BW: right-hand-side element b[i], delivered in index order 0..N-1.
REQ-008 max_iter  input  16: sweep limit, sampled on the first accepted in_en of a problem.
REQ-009 tol  input  XW: convergence threshold (Q.16), sampled with max_iter.
REQ-010 out_ready  input  1: downstream accepts x_out this cycle.
REQ-011 out_valid  output  1: x_out holds a result element.
REQ-012 x_out  output  XW: solution element x[k], emitted in order k = 0..N-1.
REQ-013 busy  output  1: high from the first accepted in_en until the last output handshake.
REQ-014 iter_used  output  16: number of completed sweeps for the current result; held until the next problem loads.

Function
REQ-015 The block solves M*x = b by Gauss-Seidel, where M is the banded symmetric matrix with diagonal 20, off-diagonals at distance 1/2/3 equal to -13/+6/-1, and zeros elsewhere.
REQ-016 Neighbours with index <0 or >N-1 contribute 0.
REQ-017 FSM states are IDLE, LOAD, SWEEP, OUT; the reset state is IDLE.
REQ-018 IDLE->LOAD on in_en=1: store b[0], sample max_iter and tol, set busy=1.
REQ-019 In LOAD, each in_en=1 cycle stores the next b; in_en=0 cycles are gaps and do not advance the index.
REQ-020 LOAD->SWEEP in the cycle after b[N-1] is stored; all x are initialised to 0.
REQ-021 in_en is ignored in SWEEP and OUT; it is not buffered.
REQ-022 SWEEP updates one unknown per cycle, i = 0..N-1, using the newest values of x (in-place update).
REQ-023 Numerator: num = (b[i]<<16) + 13*(x[i-1]+x[i+1]) - 6*(x[i-2]+x[i+2]) + (x[i-3]+x[i+3]), computed at XW+8 bits with no intermediate overflow.
REQ-024 New value: x[i] = (num * 52429) >>> 20, an arithmetic shift that floors the result; it saturates to the XW signed range.
REQ-025 Per sweep, track d = max over i of |x_new - x_old|.
REQ-026 At the end of a sweep, iter_used is incremented.
REQ-027 SWEEP->OUT when d < tol or iter_used == max_iter; otherwise the next sweep starts the following cycle.
REQ-028 max_iter=0 is treated as 1.
REQ-029 In OUT, out_valid=1 and x_out=x[k].
REQ-030 k advances only on a cycle with out_valid && out_ready; x_out is held stable while stalled.
REQ-031 After the handshake of x[N-1], the next cycle has out_valid=0, busy=0, and the FSM in IDLE.
REQ-032 An in_en in that same handshake cycle is ignored.
REQ-033 Latency with no gaps and out_ready=1: first out_valid occurs N + S*N + 1 cycles after the first in_en, where S is the number of sweeps.

Reset
REQ-034 On reset=0, asynchronously: out_valid=0, x_out=0, busy=0, iter_used=0, the FSM goes to IDLE, and load/sweep/output indices are cleared.
REQ-035 Reset asserted mid-LOAD, mid-SWEEP or mid-OUT discards the problem; no partial result is emitted after release.
REQ-036 The first in_en accepted after reset release starts a new problem.

Verification
REQ-037 Zero RHS: b all 0, tol=1, max_iter=10 -> after 1 sweep iter_used=1; 16 outputs, all 0x00000000.
REQ-038 Single sweep: b[0]=20, others 0, max_iter=1 -> x_out[0]=0x00010000, x_out[1]=0x0000A666.
REQ-039 Golden 16-element problem: max_iter=200, tol=0 -> bench computes M*x_f - b in real arithmetic; squared error < 1e-6; iter_used=200.
REQ-040 Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly -> exactly N handshakes, in order, no duplicates; x_out stable during stalls.
REQ-041 Gaps and busy input: in_en has 3 idle cycles inside LOAD, and extra in_en pulses during SWEEP -> results identical to the gap-free run.
REQ-042 Reset mid-SWEEP: assert reset at sweep 2, release, load a new problem -> outputs correspond only to the new b; busy=0 and out_valid=0 while reset is low.
